// File: rtl/gb_bus_arbiter.sv
// gb_bus_arbiter
// Shares one external bus among NUM_M masters (index 0 is the CPU). A master
// that wins arbitration has its address, write data and direction captured
// into hold registers. The bus cycle then runs for CYCLE_LEN clocks. At the
// end of the cycle the read data is returned, a one-clock ack is pulsed, and
// the bus is re-arbitrated back-to-back.
//
// Optional feature: define GB_BUS_ARB_ROUND_ROBIN_EN for rotating priority
// (search starts at last_grant+1). Otherwise the lowest requesting index wins.
//
// Ports:
//   clk, rst          system clock, async active-low reset
//   m_req/m_lock/m_wr per-master request, burst lock, write(1)/read(0)
//   m_a, m_dout       per-master address / write data (master i at [i*W +: W])
//   m_gnt, m_ack      one-hot grant, one-clock completion pulse
//   m_din             read data returned to the acked master
//   a, dout, din      shared bus address, write data, read data
//   wr, rd, cs, busy  bus strobes and cycle-in-progress flag
//
// state  | meaning
// IDLE   | bus free, all bus outputs 0, waiting for any m_req
// ACTIVE | bus cycle in progress, cnt counts 0..CYCLE_LEN-1
module gb_bus_arbiter #(
   parameter int NUM_M     = 3,
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int CYCLE_LEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_req,
   input  logic [NUM_M-1:0]    m_lock,
   input  logic [NUM_M-1:0]    m_wr,
   input  logic [NUM_M*AW-1:0] m_a,
   input  logic [NUM_M*DW-1:0] m_dout,
   output logic [NUM_M-1:0]    m_gnt,
   output logic [NUM_M-1:0]    m_ack,
   output logic [DW-1:0]       m_din,
   output logic [AW-1:0]       a,
   output logic [DW-1:0]       dout,
   input  logic [DW-1:0]       din,
   output logic                wr,
   output logic                rd,
   output logic                cs,
   output logic                busy
);

   localparam int CW = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
   localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE_LEN - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [AW-1:0]    hold_a;
   logic [DW-1:0]    hold_dout;
   logic             hold_wr;

   logic             any_req;
   logic             lock_hit;
   logic [NUM_M-1:0] win_oh;
   logic [IW-1:0]    win_idx;
   logic [AW-1:0]    sel_a;
   logic [DW-1:0]    sel_dout;
   logic             sel_wr;

`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]    last_grant;
   logic             found;
   int               idx;
`endif

   assign any_req = |m_req;
   // m_gnt is zero in IDLE, so a lock can only hold the master that owns the bus.
   assign lock_hit = |(m_gnt & m_lock & m_req);

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
      found = 1'b0;
      idx   = 0;
`endif
      if (lock_hit) begin
         win_oh = m_gnt;
         for (int i = 0; i < NUM_M; i++) begin
            if (m_gnt[i]) win_idx = IW'(i);
         end
      end else begin
`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
         for (int k = 0; k < NUM_M; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && m_req[IW'(idx)]) begin
               found   = 1'b1;
               win_idx = IW'(idx);
            end
         end
`else
         // Walk downwards so the lowest set index is the last write.
         for (int i = NUM_M - 1; i >= 0; i--) begin
            if (m_req[i]) win_idx = IW'(i);
         end
`endif
         if (any_req) win_oh[win_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_a    = '0;
      sel_dout = '0;
      sel_wr   = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (IW'(i) == win_idx) begin
            sel_a    = m_a[i*AW +: AW];
            sel_dout = m_dout[i*DW +: DW];
            sel_wr   = m_wr[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         m_gnt      <= '0;
         m_ack      <= '0;
         m_din      <= '0;
         hold_a     <= '0;
         hold_dout  <= '0;
         hold_wr    <= 1'b0;
`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
         last_grant <= IW'(NUM_M - 1);
`endif
      end else begin
         m_ack <= '0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state     <= ST_ACTIVE;
                  cnt       <= '0;
                  m_gnt     <= win_oh;
                  hold_a    <= sel_a;
                  hold_dout <= sel_dout;
                  hold_wr   <= sel_wr;
`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
                  last_grant <= win_idx;
`endif
               end
            end
            ST_ACTIVE: begin
               if (cnt == CNT_LAST) begin
                  m_ack <= m_gnt;
                  if (!hold_wr) m_din <= din;
                  if (any_req) begin
                     cnt       <= '0;
                     m_gnt     <= win_oh;
                     hold_a    <= sel_a;
                     hold_dout <= sel_dout;
                     hold_wr   <= sel_wr;
`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
                     // A locked burst keeps the rotation point where it was.
                     if (!lock_hit) last_grant <= win_idx;
`endif
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     m_gnt <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               m_gnt <= '0;
            end
         endcase
      end
   end

   // Hold registers keep stale values in IDLE; the bus is gated by state.
   assign busy = (state == ST_ACTIVE);
   assign a    = busy ? hold_a    : '0;
   assign dout = busy ? hold_dout : '0;
   assign wr   = busy &  hold_wr;
   assign rd   = busy & ~hold_wr;
   assign cs   = wr | rd;

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Directed bench for gb_bus_arbiter (NUM_M=3, AW=16, DW=8, CYCLE_LEN=4).
// Per-clock vector table for a single read and a two-master contention,
// followed by hand-written lock-burst, write-drop, reset-abort and
// (with GB_BUS_ARB_ROUND_ROBIN_EN) rotation sequences.
module tb_gb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  m_req, m_lock, m_wr;
   logic [47:0] m_a;
   logic [23:0] m_dout;
   logic [2:0]  m_gnt, m_ack;
   logic [7:0]  m_din;
   logic [15:0] a;
   logic [7:0]  dout, din;
   logic        wr, rd, cs, busy;

   int checks = 0;
   int errors = 0;

   gb_bus_arbiter #(.NUM_M(3), .AW(16), .DW(8), .CYCLE_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_lock(m_lock), .m_wr(m_wr),
      .m_a(m_a), .m_dout(m_dout),
      .m_gnt(m_gnt), .m_ack(m_ack), .m_din(m_din),
      .a(a), .dout(dout), .din(din),
      .wr(wr), .rd(rd), .cs(cs), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  wrin;
      logic [7:0]  din;
      logic [2:0]  gnt;
      logic [2:0]  ack;
      logic        busy;
      logic        rd;
      logic        wr;
      logic [15:0] a;
      logic [7:0]  dout;
      logic [7:0]  mdin;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] ack_seen;
      logic [2:0] rr_order [4];

      rst = 1'b0; m_req = '0; m_lock = '0; m_wr = '0; din = '0;
      m_a    = {16'h2222, 16'h1111, 16'hC000};
      m_dout = {8'h22, 8'hA5, 8'h00};

      //        req     wrin    din     gnt     ack    bsy  rd   wr   a         dout   mdin
      tbl[0]  = '{3'b001, 3'b000, 8'h5A, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h00};
      tbl[1]  = '{3'b000, 3'b000, 8'h5A, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h00};
      tbl[2]  = '{3'b000, 3'b000, 8'h5A, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h00};
      tbl[3]  = '{3'b000, 3'b000, 8'h5A, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h00};
      tbl[4]  = '{3'b000, 3'b000, 8'h5A, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A};
      tbl[5]  = '{3'b000, 3'b000, 8'h11, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A};
      tbl[6]  = '{3'b110, 3'b000, 8'h11, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 16'h1111, 8'hA5, 8'h5A};
      tbl[7]  = '{3'b100, 3'b000, 8'h11, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 16'h1111, 8'hA5, 8'h5A};
      tbl[8]  = '{3'b100, 3'b000, 8'h11, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 16'h1111, 8'hA5, 8'h5A};
      tbl[9]  = '{3'b100, 3'b000, 8'h11, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 16'h1111, 8'hA5, 8'h5A};
      tbl[10] = '{3'b100, 3'b100, 8'h77, 3'b100, 3'b010, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h22, 8'h77};
      tbl[11] = '{3'b000, 3'b000, 8'h88, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h22, 8'h77};
      tbl[12] = '{3'b000, 3'b000, 8'h88, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h22, 8'h77};
      tbl[13] = '{3'b000, 3'b000, 8'h88, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h22, 8'h77};
      tbl[14] = '{3'b000, 3'b000, 8'h88, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h77};

      // Reset state
      #2;
      chk("rst_gnt", 32'(m_gnt), 32'h0);
      chk("rst_ack", 32'(m_ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_bus", 32'({a, dout, wr, rd, cs}), 32'h0);
      chk("rst_mdin", 32'(m_din), 32'h0);
      tick();
      rst = 1'b1;

      // Vector table: single read, then contention with back-to-back grant
      for (int i = 0; i < 15; i++) begin
         m_req = tbl[i].req;
         m_wr  = tbl[i].wrin;
         din   = tbl[i].din;
         tick();
         chk($sformatf("v%0d_gnt", i),  32'(m_gnt), 32'(tbl[i].gnt));
         chk($sformatf("v%0d_ack", i),  32'(m_ack), 32'(tbl[i].ack));
         chk($sformatf("v%0d_busy", i), 32'(busy),  32'(tbl[i].busy));
         chk($sformatf("v%0d_rd", i),   32'(rd),    32'(tbl[i].rd));
         chk($sformatf("v%0d_wr", i),   32'(wr),    32'(tbl[i].wr));
         chk($sformatf("v%0d_cs", i),   32'(cs),    32'(tbl[i].rd | tbl[i].wr));
         chk($sformatf("v%0d_a", i),    32'(a),     32'(tbl[i].a));
         chk($sformatf("v%0d_dout", i), 32'(dout),  32'(tbl[i].dout));
         chk($sformatf("v%0d_mdin", i), 32'(m_din), 32'(tbl[i].mdin));
      end

      // Lock burst: master 2 holds the bus for three cycles while master 0 waits
      m_wr = 3'b000; din = 8'h99;
      m_req = 3'b100; m_lock = 3'b100;
      tick();
      chk("lock_first_gnt", 32'(m_gnt), 32'h4);
      m_req = 3'b101;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            m_req = 3'b001; m_lock = 3'b000;
         end
         repeat (3) tick();
         chk($sformatf("lock_c%0d_busy", c), 32'(busy), 32'h1);
         tick();
         chk($sformatf("lock_c%0d_ack", c), 32'(m_ack), 32'h4);
         chk($sformatf("lock_c%0d_gnt", c), 32'(m_gnt), (c < 2) ? 32'h4 : 32'h1);
      end
      m_req = 3'b000;
      repeat (3) tick();
      chk("lock_m0_a", 32'(a), 32'hC000);
      tick();
      chk("lock_m0_ack", 32'(m_ack), 32'h1);
      chk("lock_m0_idle", 32'(m_gnt), 32'h0);
      chk("lock_mdin", 32'(m_din), 32'h99);

      // Write then drop request and scramble inputs at cnt=1
      tick();
      din = 8'hEE;
      m_wr = 3'b010; m_a[16 +: 16] = 16'hFF40; m_dout[8 +: 8] = 8'hA5; m_req = 3'b010;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("wd_c%0d_wr", c),   32'(wr),   32'h1);
         chk($sformatf("wd_c%0d_rd", c),   32'(rd),   32'h0);
         chk($sformatf("wd_c%0d_dout", c), 32'(dout), 32'hA5);
         chk($sformatf("wd_c%0d_a", c),    32'(a),    32'hFF40);
         if (c == 1) begin
            m_req = 3'b000; m_wr = 3'b000;
            m_a[16 +: 16] = 16'h0000; m_dout[8 +: 8] = 8'h00;
         end
      end
      tick();
      chk("wd_ack", 32'(m_ack), 32'h2);
      chk("wd_mdin_hold", 32'(m_din), 32'h99);
      chk("wd_idle", 32'(busy), 32'h0);

      // Reset at cnt=2 aborts the cycle without an ack
      din = 8'h3C; m_req = 3'b001;
      repeat (3) tick();
      m_req = 3'b000;
      #2 rst = 1'b0;
      #1;
      chk("ra_gnt", 32'(m_gnt), 32'h0);
      chk("ra_busy", 32'(busy), 32'h0);
      chk("ra_bus", 32'({a, dout, wr, rd, cs}), 32'h0);
      chk("ra_mdin", 32'(m_din), 32'h0);
      #2 rst = 1'b1;
      ack_seen = '0;
      for (int c = 0; c < 6; c++) begin
         tick();
         ack_seen = ack_seen | m_ack;
      end
      chk("ra_no_ack", 32'(ack_seen), 32'h0);
      m_req = 3'b010; m_wr = 3'b000; m_a[16 +: 16] = 16'h1111;
      tick();
      chk("ra_regnt", 32'(m_gnt), 32'h2);
      chk("ra_rega", 32'(a), 32'h1111);
      m_req = 3'b000;
      repeat (4) tick();
      chk("ra_ack", 32'(m_ack), 32'h2);
      chk("ra_ackdin", 32'(m_din), 32'h3C);

`ifdef GB_BUS_ARB_ROUND_ROBIN_EN
      // Rotation with all three masters requesting continuously
      rr_order[0] = 3'b001; rr_order[1] = 3'b010; rr_order[2] = 3'b100; rr_order[3] = 3'b001;
      tick();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      m_req = 3'b111;
      tick();
      chk("rr_g0", 32'(m_gnt), 32'(rr_order[0]));
      for (int k = 1; k < 4; k++) begin
         repeat (4) tick();
         chk($sformatf("rr_g%0d", k), 32'(m_gnt), 32'(rr_order[k]));
         chk($sformatf("rr_ack%0d", k), 32'(m_ack), 32'(rr_order[k-1]));
      end
      m_req = 3'b000;
      repeat (4) tick();
`else
      rr_order[0] = 3'b000;
      chk("fp_final_idle", 32'(m_gnt), 32'(rr_order[0]));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
